// File: rtl/game_sequencer.sv
// Game-flow controller for the flappy-bird datapath: owns the game FSM, divides
// the system clock into game ticks and sequences the per-tick datapath phases.
module game_sequencer #(
  parameter int TICK_DIV        = 5000000,
  parameter int COUNTDOWN_TICKS = 30,
  parameter int DYING_TICKS     = 20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic        i_fail_in,
  input  logic [15:0] i_score_in,
  output logic [2:0]  o_state,
  output logic        o_mode_q,
  output logic        o_game_rst_n,
  output logic        o_step_move,
  output logic        o_step_collide,
  output logic        o_step_score,
  output logic [7:0]  o_countdown,
  output logic [15:0] o_hi_score
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_DYING     = 3'd3;
  localparam logic [2:0] ST_OVER      = 3'd4;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       CD_INIT   = 8'(COUNTDOWN_TICKS);
  localparam logic [7:0]       DY_INIT   = 8'(DYING_TICKS);

  logic [2:0]       r_state;
  logic             r_start_q;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             r_mode_q;
  logic             r_game_rst_n;
  logic             r_step_move;
  logic             r_move_play;
  logic             r_step_collide;
  logic             r_step_score;
  logic [7:0]       r_countdown;
  logic [7:0]       r_dying;
  logic [15:0]      r_hi_score;

  logic w_running;
  logic w_tick;
  logic w_start_edge;

  assign w_running    = (r_state == ST_COUNTDOWN) || (r_state == ST_PLAY) ||
                        (r_state == ST_DYING);
  assign w_tick       = w_running && (r_tick_cnt == TICK_LAST);
  assign w_start_edge = i_start & ~r_start_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, independent of block order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      // A button held through reset must not look like a fresh press.
      r_start_q  <= 1'b1;
      r_tick_cnt <= '0;
    end else begin
      r_start_q <= i_start;
      if (!w_running || w_tick) r_tick_cnt <= '0;
      else                      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  // Phase pipeline: a PLAY tick walks move -> collide -> score on successive
  // cycles; a DYING tick only moves the bird.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_step_move    <= 1'b0;
      r_move_play    <= 1'b0;
      r_step_collide <= 1'b0;
      r_step_score   <= 1'b0;
    end else begin
      r_step_move    <= w_tick && ((r_state == ST_PLAY) || (r_state == ST_DYING));
      r_move_play    <= w_tick && (r_state == ST_PLAY);
      r_step_collide <= r_move_play;
      r_step_score   <= r_step_collide;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_mode_q     <= 1'b0;
      r_game_rst_n <= 1'b1;
      r_countdown  <= 8'd0;
      r_dying      <= 8'd0;
      r_hi_score   <= 16'd0;
    end else begin
      r_game_rst_n <= 1'b1;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start_edge) begin
            r_game_rst_n <= 1'b0;
            r_mode_q     <= i_mode;
            r_countdown  <= CD_INIT;
            r_state      <= ST_COUNTDOWN;
          end
        end
        ST_COUNTDOWN: begin
          if (w_tick) begin
            r_countdown <= r_countdown - 8'd1;
            if (r_countdown == 8'd1) r_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (r_step_score && i_fail_in) begin
            r_state <= ST_DYING;
            r_dying <= DY_INIT;
          end
        end
        ST_DYING: begin
          if (w_tick) begin
            r_dying <= r_dying - 8'd1;
            if (r_dying == 8'd1) begin
              r_state <= ST_OVER;
              if (i_score_in > r_hi_score) r_hi_score <= i_score_in;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_state        = r_state;
  assign o_mode_q       = r_mode_q;
  assign o_game_rst_n   = r_game_rst_n;
  assign o_step_move    = r_step_move;
  assign o_step_collide = r_step_collide;
  assign o_step_score   = r_step_score;
  assign o_countdown    = r_countdown;
  assign o_hi_score     = r_hi_score;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a vector table walks a full game while a scoreboard
// checks the timing of every restart pulse and phase strobe.
module tb_game_sequencer;

  localparam int EV_GRN     = 0;
  localparam int EV_MOVE    = 1;
  localparam int EV_COLLIDE = 2;
  localparam int EV_SCORE   = 3;

  typedef struct {
    int         cyc;
    int         kind;
  } ev_t;

  typedef struct {
    int          adv;
    logic        start;
    logic        mode;
    logic        fail;
    logic [15:0] score;
    int          ev_rounds;
    logic [2:0]  e_state;
    logic [7:0]  e_cd;
    logic [15:0] e_hi;
    logic        e_mode_q;
    logic        e_grn;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic        fail_in;
  logic [15:0] score_in;
  logic [2:0]  state;
  logic        mode_q;
  logic        game_rst_n;
  logic        step_move;
  logic        step_collide;
  logic        step_score;
  logic [7:0]  countdown;
  logic [15:0] hi_score;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  ev_t  sb_q[$];
  vec_t vecs[$];

  game_sequencer #(
    .TICK_DIV(4),
    .COUNTDOWN_TICKS(3),
    .DYING_TICKS(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_mode(mode),
    .i_fail_in(fail_in),
    .i_score_in(score_in),
    .o_state(state),
    .o_mode_q(mode_q),
    .o_game_rst_n(game_rst_n),
    .o_step_move(step_move),
    .o_step_collide(step_collide),
    .o_step_score(step_score),
    .o_countdown(countdown),
    .o_hi_score(hi_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int kind);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    sb_q.push_back(e);
  endtask

  // Start edge seen at edge s: countdown lasts 3 ticks of 4 cycles, play rounds
  // start 16 cycles later, the last round fails and two dying moves follow.
  task automatic push_game(input int s, input int rounds);
    int f;
    push_ev(s, EV_GRN);
    for (int r = 0; r < rounds; r++) begin
      push_ev(s + 16 + 4 * r, EV_MOVE);
      push_ev(s + 17 + 4 * r, EV_COLLIDE);
      push_ev(s + 18 + 4 * r, EV_SCORE);
    end
    f = s + 18 + 4 * (rounds - 1);
    push_ev(f + 2, EV_MOVE);
    push_ev(f + 6, EV_MOVE);
  endtask

  task automatic sb_pop(input int kind);
    ev_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_unexpected: got event kind %0d at cycle %0d want none", kind, cyc);
    end else begin
      e = sb_q.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!game_rst_n)  sb_pop(EV_GRN);
    if (step_move)    sb_pop(EV_MOVE);
    if (step_collide) sb_pop(EV_COLLIDE);
    if (step_score)   sb_pop(EV_SCORE);
  end

  task automatic add_vec(input int adv, input logic st, input logic md, input logic fl,
                         input logic [15:0] sc, input int evr, input logic [2:0] e_state,
                         input logic [7:0] e_cd, input logic [15:0] e_hi,
                         input logic e_mq, input logic e_grn);
    vec_t v;
    v.adv = adv; v.start = st; v.mode = md; v.fail = fl; v.score = sc;
    v.ev_rounds = evr; v.e_state = e_state; v.e_cd = e_cd; v.e_hi = e_hi;
    v.e_mode_q = e_mq; v.e_grn = e_grn;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] e_state, input logic [7:0] e_cd,
                               input logic [15:0] e_hi, input logic e_mq, input logic e_grn);
    check({tag, "_state"}, 32'(state), 32'(e_state));
    check({tag, "_countdown"}, 32'(countdown), 32'(e_cd));
    check({tag, "_hi_score"}, 32'(hi_score), 32'(e_hi));
    check({tag, "_mode_q"}, 32'(mode_q), 32'(e_mq));
    check({tag, "_game_rst_n"}, 32'(game_rst_n), 32'(e_grn));
  endtask

  task automatic check_reset_values(input string tag);
    check_outputs(tag, 3'd0, 8'd0, 16'd0, 1'b0, 1'b1);
    check({tag, "_strobes"}, 32'({step_move, step_collide, step_score}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    // Comments give the edge index relative to the first accepted start edge S.
    //      adv st md fl score evr  state cd hi mq grn
    add_vec(2, 0, 0, 0, 16'd0, 0, 3'd0, 8'd0, 16'd0, 0, 1); // start held through reset
    add_vec(1, 1, 0, 0, 16'd0, 3, 3'd0, 8'd0, 16'd0, 0, 1); // press
    add_vec(1, 0, 0, 0, 16'd0, 0, 3'd1, 8'd3, 16'd0, 0, 0); // S: restart pulse
    add_vec(1, 0, 0, 0, 16'd0, 0, 3'd1, 8'd3, 16'd0, 0, 1); // S+1
    add_vec(3, 0, 0, 0, 16'd0, 0, 3'd1, 8'd2, 16'd0, 0, 1); // S+4
    add_vec(4, 0, 0, 0, 16'd0, 0, 3'd1, 8'd1, 16'd0, 0, 1); // S+8
    add_vec(3, 0, 0, 0, 16'd0, 0, 3'd1, 8'd1, 16'd0, 0, 1); // S+11
    add_vec(1, 0, 0, 0, 16'd0, 0, 3'd2, 8'd0, 16'd0, 0, 1); // S+12 PLAY
    add_vec(4, 0, 0, 1, 16'd0, 0, 3'd2, 8'd0, 16'd0, 0, 1); // S+16 move, fail high
    add_vec(1, 0, 0, 0, 16'd0, 0, 3'd2, 8'd0, 16'd0, 0, 1); // S+17 collide
    add_vec(1, 0, 0, 0, 16'd0, 0, 3'd2, 8'd0, 16'd0, 0, 1); // S+18 score
    add_vec(1, 0, 0, 1, 16'd0, 0, 3'd2, 8'd0, 16'd0, 0, 1); // S+19 quiet
    add_vec(1, 1, 0, 1, 16'd0, 0, 3'd2, 8'd0, 16'd0, 0, 1); // S+20 move, press
    add_vec(1, 0, 0, 1, 16'd0, 0, 3'd2, 8'd0, 16'd0, 0, 1); // S+21 collide
    add_vec(1, 0, 0, 0, 16'd7, 0, 3'd2, 8'd0, 16'd0, 0, 1); // S+22 score
    add_vec(1, 0, 0, 0, 16'd7, 0, 3'd2, 8'd0, 16'd0, 0, 1); // S+23
    add_vec(3, 0, 0, 1, 16'd7, 0, 3'd2, 8'd0, 16'd0, 0, 1); // S+26 score, fail
    add_vec(1, 1, 0, 0, 16'd7, 0, 3'd3, 8'd0, 16'd0, 0, 1); // S+27 DYING, press
    add_vec(1, 0, 0, 0, 16'd7, 0, 3'd3, 8'd0, 16'd0, 0, 1); // S+28
    add_vec(3, 1, 0, 0, 16'd7, 0, 3'd3, 8'd0, 16'd0, 0, 1); // S+31, press on OVER edge
    add_vec(1, 1, 0, 0, 16'd7, 0, 3'd4, 8'd0, 16'd7, 0, 1); // S+32 OVER
    add_vec(2, 0, 0, 0, 16'd7, 0, 3'd4, 8'd0, 16'd7, 0, 1); // S+34

    rst = 1'b0; start = 1'b1; mode = 1'b0; fail_in = 1'b0; score_in = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("in_reset");
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].adv) @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].e_state, vecs[i].e_cd, vecs[i].e_hi,
                    vecs[i].e_mode_q, vecs[i].e_grn);
      start    = vecs[i].start;
      mode     = vecs[i].mode;
      fail_in  = vecs[i].fail;
      score_in = vecs[i].score;
      if (vecs[i].ev_rounds > 0) push_game(cyc + 1, vecs[i].ev_rounds);
    end

    // Second game from OVER in two-player mode, lower score keeps hi_score.
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1;
    s = cyc + 1;
    push_game(s, 1);
    @(posedge clk); #1;
    check_outputs("g2_start", 3'd1, 8'd3, 16'd7, 1'b1, 1'b0);
    start = 1'b0; mode = 1'b0;
    @(posedge clk); #1;
    check_outputs("g2_s1", 3'd1, 8'd3, 16'd7, 1'b1, 1'b1);
    repeat (17) @(posedge clk); #1;
    check("g2_score_strobe", 32'(step_score), 32'd1);
    fail_in = 1'b1; score_in = 16'd5;
    @(posedge clk); #1;
    check("g2_dying", 32'(state), 32'd3);
    fail_in = 1'b0;
    repeat (5) @(posedge clk); #1;
    check_outputs("g2_over", 3'd4, 8'd0, 16'd7, 1'b1, 1'b1);

    // Third game, reset lands between step_move and step_collide.
    start = 1'b1;
    s = cyc + 1;
    push_ev(s, EV_GRN);
    push_ev(s + 16, EV_MOVE);
    @(posedge clk); #1;
    check("g3_state", 32'(state), 32'd1);
    start = 1'b0;
    repeat (16) @(posedge clk); #1;
    check("g3_move", 32'(step_move), 32'd1);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_values("mid_play_rst");
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    repeat (12) @(posedge clk); #1;
    check_reset_values("after_rst");

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
